// File: rtl/lc3_regdump.sv
// rtl/lc3_regdump.sv - LC-3 register file debug dump engine
// Walks a wrap-around register range over one read port, streaming values then a checksum.
module lc3_regdump (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  first_reg,
  input  logic [2:0]  last_reg,
  output logic [2:0]  rd_sel,
  input  logic [15:0] rd_data,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic        busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;
  localparam logic [1:0] S_CHK   = 2'd3;

  logic [1:0]  r_state;
  logic [2:0]  r_ptr;
  logic [2:0]  r_last;
  logic [15:0] r_sum;
  logic [15:0] r_tx_data;
  logic        r_tx_valid;
  logic        r_tx_last;

  logic        w_xfer;
  logic [15:0] w_sum_next;

  assign w_xfer     = r_tx_valid & tx_ready;
  assign w_sum_next = r_sum + rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= 3'd0;
      r_last     <= 3'd0;
      r_sum      <= 16'h0000;
      r_tx_data  <= 16'h0000;
      r_tx_valid <= 1'b0;
      r_tx_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ptr   <= first_reg;
            r_last  <= last_reg;
            r_sum   <= 16'h0000;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_tx_data  <= rd_data;
          r_sum      <= w_sum_next;
          r_tx_valid <= 1'b1;
          r_state    <= S_SEND;
        end
        S_SEND: begin
          if (w_xfer) begin
            // r_sum already includes the register just sent
            if (r_ptr == r_last) begin
              r_tx_data <= r_sum;
              r_tx_last <= 1'b1;
              r_state   <= S_CHK;
            end else begin
              r_ptr      <= r_ptr + 3'd1;
              r_tx_valid <= 1'b0;
              r_state    <= S_FETCH;
            end
          end
        end
        default: begin
          if (w_xfer) begin
            r_tx_valid <= 1'b0;
            r_tx_last  <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign rd_sel   = (r_state == S_FETCH || r_state == S_SEND) ? r_ptr : 3'd0;
  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign tx_last  = r_tx_last;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_lc3_regdump.sv
// tb/tb_lc3_regdump.sv - self-checking bench for lc3_regdump
// A register-file model drives rd_data; dumps are compared against a range/sum reference.
module tb_lc3_regdump;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  first_reg;
  logic [2:0]  last_reg;
  logic [2:0]  rd_sel;
  logic [15:0] rd_data;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_last;
  logic        busy;

  logic [15:0] rf [8];
  logic [15:0] ld_vals [8];
  logic [15:0] m_rf [8];
  logic        ld;
  logic        wr_en;
  logic        wr_arm;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;

  logic [15:0] got_w [$];
  logic        got_l [$];
  logic [2:0]  got_s [$];
  logic [15:0] exp_w [$];
  logic [2:0]  exp_s [$];
  int          done_edge;
  int          checks = 0;
  int          errors = 0;

  lc3_regdump dut (
    .clk(clk), .rst_n(rst_n), .start(start), .first_reg(first_reg), .last_reg(last_reg),
    .rd_sel(rd_sel), .rd_data(rd_data), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_last(tx_last), .busy(busy)
  );

  always #5 clk = ~clk;

  assign rd_data = rf[rd_sel];

  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 8; i++) rf[i] <= ld_vals[i];
    end else if (wr_en) begin
      rf[wr_addr] <= wr_data;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic random_vals);
    for (int i = 0; i < 8; i++) begin
      ld_vals[i] = random_vals ? 16'($urandom) : 16'(16'h1111 * i);
      m_rf[i]    = ld_vals[i];
    end
    ld = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0;
  endtask

  // Reference: registers first..last walking mod 8, then their 16-bit sum.
  task automatic build_exp(input logic [2:0] f, input logic [2:0] l);
    logic [15:0] s;
    logic [2:0]  idx;
    exp_w.delete(); exp_s.delete();
    s = 16'h0000;
    idx = f;
    for (int n = 0; n < 8; n++) begin
      exp_w.push_back(m_rf[idx]);
      exp_s.push_back(idx);
      s = s + m_rf[idx];
      if (idx == l) break;
      idx = idx + 3'd1;
    end
    exp_w.push_back(s);
    exp_s.push_back(3'd0);
  endtask

  task automatic run_dump(input logic [2:0] f, input logic [2:0] l, input int mode, input int abort_after);
    int          edge_n;
    int          bp;
    logic        hold;
    logic [15:0] prev_d;
    logic        prev_l;
    got_w.delete(); got_l.delete(); got_s.delete();
    done_edge = -1;
    first_reg = f; last_reg = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edge_n = 0; bp = 0; hold = 1'b0; prev_d = '0; prev_l = 1'b0;
    chk("busy_rise", {15'd0, busy}, 16'd1);
    while (1) begin
      if (hold) begin
        chk("hold_valid", {15'd0, tx_valid}, 16'd1);
        chk("hold_data", tx_data, prev_d);
        chk("hold_last", {15'd0, tx_last}, {15'd0, prev_l});
      end
      start = 1'b0;
      case (mode)
        0: tx_ready = 1'b1;
        1: tx_ready = 1'($urandom_range(0, 1));
        default: begin
          if (tx_valid && got_w.size() == 1 && bp < 5) begin
            tx_ready = 1'b0;
            bp++;
            if (bp == 2) begin
              start = 1'b1; first_reg = 3'd5; last_reg = 3'd5;
            end
          end else begin
            tx_ready = 1'b1;
          end
        end
      endcase
      if (wr_arm && busy && !tx_valid && rd_sel == wr_addr) begin
        wr_en = 1'b1; wr_arm = 1'b0; m_rf[wr_addr] = wr_data;
      end else begin
        wr_en = 1'b0;
      end
      if (tx_valid && tx_ready) begin
        got_w.push_back(tx_data); got_l.push_back(tx_last); got_s.push_back(rd_sel);
        if (tx_last) done_edge = edge_n + 1;
        hold = 1'b0;
      end else begin
        hold = tx_valid; prev_d = tx_data; prev_l = tx_last;
      end
      @(posedge clk); #1;
      edge_n++;
      if (edge_n == done_edge) break;
      if (abort_after > 0 && got_w.size() >= abort_after) break;
      if (edge_n > 400) begin
        chk("dump_timeout_busy", {15'd0, busy}, 16'd0);
        break;
      end
    end
    wr_en = 1'b0; start = 1'b0;
  endtask

  task automatic check_dump(input string tag);
    chk({tag, "_count"}, 16'(got_w.size()), 16'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      chk({tag, "_word"}, got_w[i], exp_w[i]);
      chk({tag, "_last"}, {15'd0, got_l[i]}, (i == exp_w.size() - 1) ? 16'd1 : 16'd0);
      chk({tag, "_sel"}, {13'd0, got_s[i]}, {13'd0, exp_s[i]});
    end
    chk({tag, "_busy_end"}, {15'd0, busy}, 16'd0);
    chk({tag, "_valid_end"}, {15'd0, tx_valid}, 16'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; first_reg = '0; last_reg = '0; tx_ready = 1'b0;
    ld = 1'b0; wr_en = 1'b0; wr_arm = 1'b0; wr_addr = '0; wr_data = '0;
    preload(1'b0);
    chk("rst_tx_data", tx_data, 16'h0000);
    chk("rst_tx_valid", {15'd0, tx_valid}, 16'd0);
    chk("rst_tx_last", {15'd0, tx_last}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_rd_sel", {13'd0, rd_sel}, 16'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full range with ready held high.
    build_exp(3'd0, 3'd7);
    run_dump(3'd0, 3'd7, 0, 0);
    check_dump("full");
    chk("full_sum_const", got_w[got_w.size()-1], 16'hDDDC);
    chk("full_end_edge", 16'(done_edge), 16'd17);

    build_exp(3'd6, 3'd1);
    run_dump(3'd6, 3'd1, 0, 0);
    check_dump("wrap");
    chk("wrap_sum_const", got_w[got_w.size()-1], 16'hEEEE);

    build_exp(3'd3, 3'd3);
    run_dump(3'd3, 3'd3, 0, 0);
    check_dump("single");

    // Backpressure on the second word, with an ignored start pulse.
    build_exp(3'd0, 3'd3);
    run_dump(3'd0, 3'd3, 2, 0);
    check_dump("bp");
    chk("bp_word1", got_w[1], 16'h1111);

    // R2 written on its own FETCH edge: old value is dumped.
    wr_arm = 1'b1; wr_addr = 3'd2; wr_data = 16'hABCD;
    build_exp(3'd1, 3'd3);
    run_dump(3'd1, 3'd3, 0, 0);
    check_dump("wrcol");
    chk("wrcol_old", got_w[1], 16'h2222);
    build_exp(3'd2, 3'd2);
    run_dump(3'd2, 3'd2, 0, 0);
    check_dump("wrnew");
    chk("wrnew_val", got_w[0], 16'hABCD);

    // Asynchronous reset after the third word.
    run_dump(3'd0, 3'd7, 0, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {15'd0, tx_valid}, 16'd0);
    chk("arst_busy", {15'd0, busy}, 16'd0);
    chk("arst_last", {15'd0, tx_last}, 16'd0);
    chk("arst_data", tx_data, 16'h0000);
    chk("arst_sel", {13'd0, rd_sel}, 16'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    build_exp(3'd4, 3'd6);
    run_dump(3'd4, 3'd6, 0, 0);
    check_dump("post_rst");

    // Random contents, ranges and ready patterns.
    for (int t = 0; t < 8; t++) begin
      logic [2:0] f, l;
      preload(1'b1);
      f = 3'($urandom_range(0, 7));
      l = 3'($urandom_range(0, 7));
      build_exp(f, l);
      run_dump(f, l, 1, 0);
      check_dump("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc3_regdump.md
# lc3_regdump

Debug read-out engine for the LC-3 register file. On a start pulse it walks a contiguous, wrap-around range of registers R0–R7 through one register-file read port. It streams each 16-bit value, followed by a 16-bit checksum word, over a valid/ready word channel to the debug/host link. It is the reading end of the register file: the datapath writes through the DR/LD_REG port, and this block reads through an SR port that the top level muxes to it while `busy` is high.

## Interface
Parameters: none. The block is fixed to 8 registers × 16 bits.

- `clk`  in  1  system clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  single-cycle request to begin a dump; sampled only in IDLE
- `first_reg`  in  3  first register to dump; latched when `start` is accepted
- `last_reg`  in  3  last register to dump, inclusive; latched when `start` is accepted
- `rd_sel`  out  3  register index driven to the register-file SR select
- `rd_data`  in  16  combinational SRout of the register file for `rd_sel`
- `tx_data`  out  16  output word, registered
- `tx_valid`  out  1  `tx_data` is valid
- `tx_ready`  in  1  sink accepts the word; a transfer occurs on an edge where `tx_valid` and `tx_ready` are both 1
- `tx_last`  out  1  the current word is the checksum, the final word of the dump
- `busy`  out  1  high in every state except IDLE

## Operation
- State machine states: IDLE, FETCH, SEND, CHK. The block holds a 3-bit pointer `ptr`, latched `first`/`last`, and a 16-bit `sum`.
- IDLE → FETCH when `start`=1:
  - latch `first_reg` and `last_reg`
  - set `ptr`=`first_reg` and `sum`=0
- While not IDLE, `start` is ignored.
- FETCH, which lasts one cycle:
  - `rd_sel`=`ptr`
  - at the edge: `tx_data`←`rd_data`, `sum`←`sum`+`rd_data` (mod 2^16), `tx_valid`←1, then → SEND.
- SEND: `tx_data` and `tx_valid` are held stable until the transfer edge. At that edge:
  - if `ptr`==`last`: `tx_data`←`sum`+0 (the final sum, which already includes this register), `tx_last`←1, `tx_valid` stays 1, → CHK
  - otherwise: `ptr`←`ptr`+1 mod 8, `tx_valid`←0, → FETCH
- CHK: hold the word until the transfer edge. At that edge: `tx_valid`←0, `tx_last`←0, → IDLE.
- Range wrap-around: the pointer increments mod 8.
  - `last`<`first` dumps `first`..7, then 0..`last`
  - `first`==`last` dumps exactly one register plus the checksum
  - the range 0..7 dumps all 8 registers
- `rd_sel` = `ptr` in FETCH and SEND, and 0 in IDLE and CHK.
- Simultaneous register write: a datapath write to register `ptr` on the FETCH edge does not affect the captured value. The old contents are dumped, because the read is combinational before the write lands.
- The checksum is the 16-bit wrap-around sum of all dumped words, with carries discarded.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-dump): state=IDLE, `ptr`=0, `sum`=0, `tx_data`=0x0000, `tx_valid`=0, `tx_last`=0, `busy`=0, `rd_sel`=0. The dump in progress is abandoned and no partial checksum is emitted.
- `busy` rises on the edge that accepts `start`. It falls on the checksum transfer edge.
- `tx_valid` rises on the 2nd edge counting the `start`-accept edge as edge 0, i.e. one edge after it.
- With `tx_ready` held at 1, each register word takes 2 cycles (FETCH + SEND), and the checksum takes 1 cycle. A full 0..7 dump ends on edge 17.
- `tx_ready` may toggle arbitrarily. `tx_data` and `tx_last` must not change while `tx_valid`=1 and no transfer has occurred.
- A new `start` is accepted at the earliest on the edge after the return to IDLE.

## Test plan
- Preload Rn=0x1111·n and dump `first`=0, `last`=7 with `tx_ready`=1 → words 0x0000, 0x1111 … 0x7777, then 0xDDDC with `tx_last`=1. The final transfer occurs on edge 17 and `busy` falls there.
- Wrap range `first`=6, `last`=1 → words 0x6666, 0x7777, 0x0000, 0x1111, then checksum 0xEEEE. `rd_sel` sequence is 6, 7, 0, 1.
- Single register `first`=`last`=3 → word 0x3333, then 0x3333 with `tx_last`=1. There is no other output.
- Backpressure: hold `tx_ready`=0 for 5 cycles on the 2nd word → `tx_valid`=1 and `tx_data`=0x1111 stay stable throughout, and no word is lost or duplicated. Pulse `start` during this time → it is ignored.
- Concurrent write: during the FETCH cycle for R2 (0x2222), write 0xABCD to R2 via LD_REG → 0x2222 is dumped, and the checksum uses 0x2222. A later dump shows 0xABCD.
- Reset mid-dump: assert `rst_n`=0 after the 3rd word → `tx_valid`, `busy` and `tx_last` go to 0 immediately. A subsequent `start` dumps cleanly from `first_reg`.
